// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register: valid/ready handshake, 2-entry skid buffer,
// flush to bubble, registered in_ready and a saturating downstream-stall counter.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] s_data;
    logic              in_xfer;
    logic              out_xfer;

    always_comb begin
        in_xfer  = in_valid & in_ready;
        out_xfer = out_valid & out_ready;
    end

    // out_data is the main register M; in_ready/out_valid are loaded with the
    // values implied by the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
            s_data    <= BUBBLE;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= BUBBLE;
            s_data    <= BUBBLE;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state     <= ONE;
                        out_valid <= 1'b1;
                        out_data  <= in_data;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_data <= in_data;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_data  <= BUBBLE;
                    end else if (in_xfer) begin
                        state    <= FULL;
                        s_data   <= in_data;
                        in_ready <= 1'b0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain from S into M can happen.
                    if (out_xfer) begin
                        state    <= ONE;
                        out_data <= s_data;
                        s_data   <= BUBBLE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    out_data  <= BUBBLE;
                    s_data    <= BUBBLE;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a saturation instance.
module tb_pipe_stage_skid;

    localparam int unsigned       DW  = 16;
    localparam logic [DW-1:0]     BUB = 16'h0013;
    localparam logic [7:0]        SBUB = 8'hA5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic [15:0]   stall_cnt;

    logic          s_in_valid = 1'b0;
    logic [7:0]    s_in_data = '0;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [7:0]    s_out_data;
    logic          s_out_ready = 1'b0;
    logic          s_flush = 1'b0;
    logic [3:0]    s_stall_cnt;

    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .BUBBLE(SBUB), .CNT_W(4)) sat_dut (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(s_out_ready), .flush(s_flush), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose head is shown on the output.
    logic [DW-1:0] mq[$];
    int unsigned   m_stall = 0;
    bit            m_acc;
    bit            m_pop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_stall = 0;
        end else begin
            m_acc = in_valid && (mq.size() < 2);
            m_pop = (mq.size() > 0) && out_ready;
            if (mq.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) mq.delete(0);
                if (m_acc) mq.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("out_data", 64'(out_data), (mq.size() > 0) ? 64'(mq[0]) : 64'(BUB));
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            if (!out_valid) check("bubble_rule", 64'(out_data), 64'(BUB));
            if (!s_out_valid) check("sat_bubble_rule", 64'(s_out_data), 64'(SBUB));
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 reset = 1'b0;
        tick();

        // Asynchronous reset mid-cycle while M holds 0xAA
        drive(1'b1, 16'h00AA, 1'b0, 1'b0); tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0); tick();
        check("pre_reset_data", 64'(out_data), 64'h00AA);
        check("pre_reset_stall", 64'(stall_cnt), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'(BUB));
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        #3 reset = 1'b0;

        // Streaming with out_ready held high
        drive(1'b1, 16'h0001, 1'b1, 1'b0); tick();
        check("stream_d1", 64'(out_data), 64'h1);
        drive(1'b1, 16'h0002, 1'b1, 1'b0); tick();
        check("stream_d2", 64'(out_data), 64'h2);
        drive(1'b1, 16'h0003, 1'b1, 1'b0); tick();
        check("stream_d3", 64'(out_data), 64'h3);
        check("stream_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("stream_end_valid", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Skid under backpressure
        drive(1'b1, 16'h0010, 1'b0, 1'b0); tick();
        check("skid_m0", 64'(out_data), 64'h10);
        check("skid_rdy0", 64'(in_ready), 64'd1);
        drive(1'b1, 16'h0011, 1'b0, 1'b0); tick();
        check("skid_full_rdy", 64'(in_ready), 64'd0);
        drive(1'b1, 16'h0012, 1'b0, 1'b0); tick();
        check("skid_hold_m", 64'(out_data), 64'h10);
        check("skid_hold_rdy", 64'(in_ready), 64'd0);
        check("skid_stall", 64'(stall_cnt), 64'd2);
        drive(1'b1, 16'h0012, 1'b1, 1'b0); tick();
        check("skid_drain1", 64'(out_data), 64'h11);
        drive(1'b1, 16'h0012, 1'b1, 1'b0); tick();
        check("skid_drain2", 64'(out_data), 64'h12);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("skid_empty", 64'(out_valid), 64'd0);
        check("skid_stall_end", 64'(stall_cnt), 64'd2);

        // Flush while FULL with a same-cycle input offered
        drive(1'b1, 16'h0020, 1'b0, 1'b0); tick();
        drive(1'b1, 16'h0021, 1'b0, 1'b0); tick();
        check("flush_pre_rdy", 64'(in_ready), 64'd0);
        drive(1'b1, 16'h0022, 1'b0, 1'b1); tick();
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_data", 64'(out_data), 64'(BUB));
        check("flush_rdy", 64'(in_ready), 64'd1);
        check("flush_stall", 64'(stall_cnt), 64'd4);
        drive(1'b0, 16'h0000, 1'b1, 1'b0); tick();
        check("flush_after", 64'(out_valid), 64'd0);

        // Saturation on the CNT_W=4 instance
        s_in_valid = 1'b1; s_in_data = 8'h5C; s_out_ready = 1'b0; tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 64'(s_stall_cnt), 64'd14);
        tick();
        check("sat_15", 64'(s_stall_cnt), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", 64'(s_stall_cnt), 64'd15);
        check("sat_data", 64'(s_out_data), 64'h5C);
        check("sat_valid", 64'(s_out_valid), 64'd1);
        s_flush = 1'b1; tick();
        s_flush = 1'b0;
        check("sat_flush_cnt", 64'(s_stall_cnt), 64'd15);
        check("sat_flush_valid", 64'(s_out_valid), 64'd0);
        check("sat_flush_data", 64'(s_out_data), 64'(SBUB));

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 99) < 65, 16'($urandom), $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 3);
            tick();
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        tick(); tick(); tick();
        check("final_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
